// File: rtl/deinterleave_sched_pkg.sv
// Shared types and rate tables for the deinterleaver packet sequencer.
// rate_npairs() maps a rate byte to {supported, output pairs per symbol}.
package deinterleave_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_SIG_IN,
        S_SIG_DRAIN,
        S_WAIT_RATE,
        S_RST2,
        S_DATA_IN,
        S_DATA_DRAIN
    } state_e;

    localparam logic [7:0] SIG_RATE_DEFAULT = 8'h0B;
    localparam logic [5:0] CARRIERS_LEGACY  = 6'd48;
    localparam logic [5:0] CARRIERS_HT      = 6'd52;

    function automatic logic [5:0] rate_carriers(input logic [7:0] rate);
        return rate[7] ? CARRIERS_HT : CARRIERS_LEGACY;
    endfunction

    // Bits [6:4] must be zero; HT codes are MCS0..7, legacy codes are the 4-bit RATE field.
    function automatic logic [9:0] rate_npairs(input logic [7:0] rate);
        logic [9:0] res;
        res = 10'd0;
        if (rate[6:4] == 3'b000) begin
            if (rate[7]) begin
                case (rate[3:0])
                    4'd0:    res = {1'b1, 9'd26};
                    4'd1:    res = {1'b1, 9'd52};
                    4'd2:    res = {1'b1, 9'd78};
                    4'd3:    res = {1'b1, 9'd104};
                    4'd4:    res = {1'b1, 9'd156};
                    4'd5:    res = {1'b1, 9'd208};
                    4'd6:    res = {1'b1, 9'd234};
                    4'd7:    res = {1'b1, 9'd260};
                    default: res = 10'd0;
                endcase
            end else begin
                case (rate[3:0])
                    4'b1011: res = {1'b1, 9'd24};
                    4'b1111: res = {1'b1, 9'd36};
                    4'b1010: res = {1'b1, 9'd48};
                    4'b1110: res = {1'b1, 9'd72};
                    4'b1001: res = {1'b1, 9'd96};
                    4'b1101: res = {1'b1, 9'd144};
                    4'b1000: res = {1'b1, 9'd192};
                    4'b1100: res = {1'b1, 9'd216};
                    default: res = 10'd0;
                endcase
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/deinterleave_sched_if.sv
// Bundle between demodulator/control (master) and the packet sequencer (slave).
interface deinterleave_sched_if #(
    parameter int SYM_W = 16
);
    logic             enable;
    logic             pkt_start;
    logic [1:0]       sig_symbols;
    logic [7:0]       data_rate;
    logic [SYM_W-1:0] num_sym;
    logic             data_rate_valid;
    logic             in_strobe;
    logic             in_ready;
    logic [7:0]       deint_rate;
    logic             deint_reset;
    logic             deint_in_strobe;
    logic             deint_out_strobe;
    logic [SYM_W-1:0] sym_idx;
    logic             busy;
    logic             pkt_done;
    logic [1:0]       err;

    modport master (
        output enable, pkt_start, sig_symbols, data_rate, num_sym, data_rate_valid,
               in_strobe, deint_out_strobe,
        input  in_ready, deint_rate, deint_reset, deint_in_strobe, sym_idx, busy,
               pkt_done, err
    );

    modport slave (
        input  enable, pkt_start, sig_symbols, data_rate, num_sym, data_rate_valid,
               in_strobe, deint_out_strobe,
        output in_ready, deint_rate, deint_reset, deint_in_strobe, sym_idx, busy,
               pkt_done, err
    );
endinterface

// File: rtl/deinterleave_sched_rate_lookup.sv
// Combinational rate decode: support flag, drain pair count and carriers per symbol.
module deinterleave_sched_rate_lookup
    import deinterleave_sched_pkg::*;
(
    input  logic [7:0] rate,
    output logic       supported,
    output logic [8:0] npairs,
    output logic [5:0] carriers
);
    logic [9:0] entry;

    always_comb begin
        entry     = rate_npairs(rate);
        supported = entry[9];
        npairs    = entry[8:0];
        carriers  = rate_carriers(rate);
    end
endmodule

// File: rtl/deinterleave_sched.sv
// Per-packet sequencer for the OFDM deinterleaver: gates carrier writes, waits for
// each symbol to drain, and switches from the SIGNAL rate to the DATA rate.
module deinterleave_sched
    import deinterleave_sched_pkg::*;
#(
    parameter logic [7:0] SIG_RATE      = SIG_RATE_DEFAULT,
    parameter int         DRAIN_TIMEOUT = 1024,
    parameter int         SYM_W         = 16
) (
    input logic clock,
    input logic reset,
    deinterleave_sched_if.slave bus
);
    localparam int                TMR_W    = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DRAIN_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [5:0]       car_cnt_q, car_cnt_d;
    logic [8:0]       drain_cnt_q, drain_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       sig_rem_q, sig_rem_d;
    logic [SYM_W-1:0] num_sym_q, num_sym_d;
    logic [SYM_W-1:0] sym_idx_q, sym_idx_d;
    logic [7:0]       deint_rate_q, deint_rate_d;
    logic             deint_reset_q, deint_reset_d;
    logic             pkt_done_q, pkt_done_d;
    logic [1:0]       err_q, err_d;

    logic [7:0]       lookup_rate;
    logic             rate_ok;
    logic [8:0]       npairs;
    logic [5:0]       carriers;
    logic             in_ready;
    logic             drain_last;
    logic [SYM_W-1:0] sym_next;

    // While waiting for the DATA rate, the table is consulted for the incoming rate.
    assign lookup_rate = (state_q == S_WAIT_RATE) ? bus.data_rate : deint_rate_q;

    deinterleave_sched_rate_lookup u_rate_lookup (
        .rate      (lookup_rate),
        .supported (rate_ok),
        .npairs    (npairs),
        .carriers  (carriers)
    );

    assign in_ready   = (state_q == S_SIG_IN) || (state_q == S_DATA_IN);
    assign drain_last = bus.deint_out_strobe && ((drain_cnt_q + 9'd1) == npairs);
    assign sym_next   = sym_idx_q + SYM_W'(1);

    always_comb begin
        state_d       = state_q;
        car_cnt_d     = car_cnt_q;
        drain_cnt_d   = drain_cnt_q;
        timer_d       = timer_q;
        sig_rem_d     = sig_rem_q;
        num_sym_d     = num_sym_q;
        sym_idx_d     = sym_idx_q;
        deint_rate_d  = deint_rate_q;
        deint_reset_d = 1'b0;
        pkt_done_d    = 1'b0;
        err_d         = err_q;

        if (bus.pkt_start) begin
            // Same handling from any state, so an abort restarts with idle timing.
            state_d       = S_RST;
            deint_rate_d  = SIG_RATE;
            deint_reset_d = 1'b1;
            sig_rem_d     = (bus.sig_symbols == 2'd0) ? 2'd1 : bus.sig_symbols;
            err_d         = 2'b00;
            car_cnt_d     = 6'd0;
            drain_cnt_d   = 9'd0;
            timer_d       = '0;
        end else begin
            case (state_q)
                S_RST:  state_d = S_SIG_IN;
                S_RST2: state_d = S_DATA_IN;
                S_SIG_IN, S_DATA_IN: begin
                    if (bus.in_strobe) begin
                        if (car_cnt_q == carriers - 6'd1) begin
                            car_cnt_d   = 6'd0;
                            drain_cnt_d = 9'd0;
                            timer_d     = '0;
                            state_d     = (state_q == S_SIG_IN) ? S_SIG_DRAIN : S_DATA_DRAIN;
                        end else begin
                            car_cnt_d = car_cnt_q + 6'd1;
                        end
                    end
                end
                S_SIG_DRAIN, S_DATA_DRAIN: begin
                    if (drain_last) begin
                        drain_cnt_d = 9'd0;
                        timer_d     = '0;
                        if (state_q == S_SIG_DRAIN) begin
                            if (sig_rem_q <= 2'd1) begin
                                state_d = S_WAIT_RATE;
                            end else begin
                                sig_rem_d = sig_rem_q - 2'd1;
                                state_d   = S_SIG_IN;
                            end
                        end else begin
                            sym_idx_d = sym_next;
                            if (sym_next == num_sym_q) begin
                                pkt_done_d = 1'b1;
                                state_d    = S_IDLE;
                            end else begin
                                state_d = S_DATA_IN;
                            end
                        end
                    end else if (timer_q == TMR_LAST) begin
                        err_d[0]      = 1'b1;
                        deint_reset_d = 1'b1;
                        state_d       = S_IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                        if (bus.deint_out_strobe) begin
                            drain_cnt_d = drain_cnt_q + 9'd1;
                        end
                    end
                end
                S_WAIT_RATE: begin
                    if (bus.data_rate_valid) begin
                        if (rate_ok) begin
                            deint_rate_d  = bus.data_rate;
                            deint_reset_d = 1'b1;
                            num_sym_d     = bus.num_sym;
                            sym_idx_d     = '0;
                            if (bus.num_sym == '0) begin
                                pkt_done_d = 1'b1;
                                state_d    = S_IDLE;
                            end else begin
                                state_d = S_RST2;
                            end
                        end else begin
                            err_d[1] = 1'b1;
                            state_d  = S_IDLE;
                        end
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            car_cnt_q     <= 6'd0;
            drain_cnt_q   <= 9'd0;
            timer_q       <= '0;
            sig_rem_q     <= 2'd1;
            num_sym_q     <= '0;
            sym_idx_q     <= '0;
            deint_rate_q  <= SIG_RATE;
            deint_reset_q <= 1'b0;
            pkt_done_q    <= 1'b0;
            err_q         <= 2'b00;
        end else if (bus.enable) begin
            state_q       <= state_d;
            car_cnt_q     <= car_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
            timer_q       <= timer_d;
            sig_rem_q     <= sig_rem_d;
            num_sym_q     <= num_sym_d;
            sym_idx_q     <= sym_idx_d;
            deint_rate_q  <= deint_rate_d;
            deint_reset_q <= deint_reset_d;
            pkt_done_q    <= pkt_done_d;
            err_q         <= err_d;
        end else begin
            // Pulses must stay single-cycle even if enable drops right after them.
            deint_reset_q <= 1'b0;
            pkt_done_q    <= 1'b0;
        end
    end

    assign bus.in_ready        = in_ready;
    assign bus.deint_in_strobe = bus.in_strobe & in_ready & bus.enable;
    assign bus.deint_rate      = deint_rate_q;
    assign bus.deint_reset     = deint_reset_q;
    assign bus.sym_idx         = sym_idx_q;
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.pkt_done        = pkt_done_q;
    assign bus.err             = err_q;
endmodule
